// File: rtl/bp_cfg_responder_if.sv
// Config-bus command/response channel between the host-side cfg loader (master)
// and a tile's configuration responder (slave).
interface bp_cfg_responder_if #(
  parameter int addr_width_p = 16,
  parameter int data_width_p = 64
);
  logic                    cmd_v_i;
  logic                    cmd_ready_o;
  logic                    cmd_w_i;
  logic [addr_width_p-1:0] cmd_addr_i;
  logic [data_width_p-1:0] cmd_data_i;
  logic                    resp_v_o;
  logic                    resp_yumi_i;
  logic                    resp_w_o;
  logic                    resp_err_o;
  logic [data_width_p-1:0] resp_data_o;

  modport slave (
    input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    output cmd_ready_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o
  );

  modport master (
    output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    input  cmd_ready_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o
  );
endinterface

// File: rtl/bp_cfg_responder.sv
// Per-tile configuration register block: accepts one config-bus command at a
// time, holds the runtime config registers and returns one response per command.
module bp_cfg_responder #(
  parameter int cfg_id_p        = 2,
  parameter int core_id_width_p = 3,
  parameter int did_width_p     = 3,
  parameter int addr_width_p    = 16,
  parameter int data_width_p    = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bp_cfg_responder_if.slave          bus,
  output logic                       freeze_o,
  output logic [core_id_width_p-1:0] core_id_o,
  output logic [did_width_p-1:0]     did_o,
  output logic [1:0]                 icache_mode_o,
  output logic [1:0]                 dcache_mode_o,
  output logic                       cce_mode_o
);

  localparam int unsigned NumRegs = 7;
  localparam logic [2:0]  CfgIdx  = 3'd6;
  localparam logic [6:0]  CfgId   = 7'(cfg_id_p);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                     state_q, state_d;
  logic                       resp_w_q, resp_w_d;
  logic                       resp_err_q, resp_err_d;
  logic [data_width_p-1:0]    resp_data_q, resp_data_d;
  logic                       freeze_q, freeze_d;
  logic [core_id_width_p-1:0] core_id_q, core_id_d;
  logic [did_width_p-1:0]     did_q, did_d;
  logic [1:0]                 icache_q, icache_d;
  logic [1:0]                 dcache_q, dcache_d;
  logic                       cce_q, cce_d;

  logic       mapped;
  logic [2:0] idx;
  logic       cmd_err;
  logic       unused_data;

  // Mapped means 8-byte aligned and inside the 7-entry window, over the full address.
  function automatic logic addr_mapped(input logic [addr_width_p-1:0] a);
    logic [addr_width_p-1:0] word;
    word = a >> 3;
    return (a[2:0] == 3'b000) && (word < addr_width_p'(NumRegs));
  endfunction

  function automatic logic [data_width_p-1:0] read_reg(input logic [2:0] i);
    logic [data_width_p-1:0] v;
    v = '0;
    case (i)
      3'd0:    v = data_width_p'(freeze_q);
      3'd1:    v = data_width_p'(core_id_q);
      3'd2:    v = data_width_p'(did_q);
      3'd3:    v = data_width_p'(icache_q);
      3'd4:    v = data_width_p'(dcache_q);
      3'd5:    v = data_width_p'(cce_q);
      3'd6:    v = data_width_p'(CfgId);
      default: v = '0;
    endcase
    return v;
  endfunction

  assign mapped      = addr_mapped(bus.cmd_addr_i);
  assign idx         = bus.cmd_addr_i[5:3];
  assign cmd_err     = !mapped || (bus.cmd_w_i && (idx == CfgIdx));
  assign unused_data = ^bus.cmd_data_i;

  always_comb begin
    state_d     = state_q;
    resp_w_d    = resp_w_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    freeze_d    = freeze_q;
    core_id_d   = core_id_q;
    did_d       = did_q;
    icache_d    = icache_q;
    dcache_d    = dcache_q;
    cce_d       = cce_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_v_i) begin
          state_d     = RESP;
          resp_w_d    = bus.cmd_w_i;
          resp_err_d  = cmd_err;
          // Read data is captured here, so it always reflects the pre-write value.
          resp_data_d = (!bus.cmd_w_i && !cmd_err) ? read_reg(idx) : '0;
          if (bus.cmd_w_i && !cmd_err) begin
            case (idx)
              3'd0:    freeze_d  = bus.cmd_data_i[0];
              3'd1:    core_id_d = bus.cmd_data_i[core_id_width_p-1:0];
              3'd2:    did_d     = bus.cmd_data_i[did_width_p-1:0];
              3'd3:    icache_d  = bus.cmd_data_i[1:0];
              3'd4:    dcache_d  = bus.cmd_data_i[1:0];
              3'd5:    cce_d     = bus.cmd_data_i[0];
              default: ;
            endcase
          end
        end
      end
      RESP: begin
        if (bus.resp_yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      resp_w_q    <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      freeze_q    <= 1'b1;
      core_id_q   <= '0;
      did_q       <= '0;
      icache_q    <= 2'b00;
      dcache_q    <= 2'b00;
      cce_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_w_q    <= resp_w_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      freeze_q    <= freeze_d;
      core_id_q   <= core_id_d;
      did_q       <= did_d;
      icache_q    <= icache_d;
      dcache_q    <= dcache_d;
      cce_q       <= cce_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE) && !reset_i;
  assign bus.resp_v_o    = (state_q == RESP);
  assign bus.resp_w_o    = resp_w_q;
  assign bus.resp_err_o  = resp_err_q;
  assign bus.resp_data_o = resp_data_q;

  assign freeze_o      = freeze_q;
  assign core_id_o     = core_id_q;
  assign did_o         = did_q;
  assign icache_mode_o = icache_q;
  assign dcache_mode_o = dcache_q;
  assign cce_mode_o    = cce_q;

`ifndef SYNTHESIS
  a_yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.resp_yumi_i && !bus.resp_v_o))
    else $error("resp_yumi_i asserted without resp_v_o");
`endif

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Randomized scoreboard bench for bp_cfg_responder with a register-array reference model.
module tb_bp_cfg_responder;
  localparam int AW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_cfg_responder_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

  logic       freeze;
  logic [2:0] core_id;
  logic [2:0] did;
  logic [1:0] icache;
  logic [1:0] dcache;
  logic       cce;

  bp_cfg_responder #(
    .cfg_id_p(2), .core_id_width_p(3), .did_width_p(3),
    .addr_width_p(AW), .data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus),
    .freeze_o(freeze), .core_id_o(core_id), .did_o(did),
    .icache_mode_o(icache), .dcache_mode_o(dcache), .cce_mode_o(cce)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic        err;
    logic [63:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [63:0] model[7];
  int          wid[7] = '{1, 3, 3, 2, 2, 1, 7};

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) model[i] = 64'd0;
    model[0] = 64'd1;
    model[6] = 64'd2;
  endfunction

  // Register index = address / 8; anything misaligned or past 0x30 is unmapped.
  function automatic resp_t predict(input logic w, input logic [15:0] a, input logic [63:0] d);
    resp_t r;
    int    i;
    bit    ok;
    ok     = (a % 8 == 0) && (a / 8 < 7);
    i      = a / 8;
    r.w    = w;
    r.err  = !ok || (w && i == 6);
    r.data = 64'd0;
    if (!r.err) begin
      if (w) model[i] = d & ((64'd1 << wid[i]) - 64'd1);
      else   r.data = model[i];
    end
    return r;
  endfunction

  task automatic chk_cfg(input string tag);
    chk({tag, "_freeze"},  {63'd0, freeze},  model[0]);
    chk({tag, "_core_id"}, {61'd0, core_id}, model[1]);
    chk({tag, "_did"},     {61'd0, did},     model[2]);
    chk({tag, "_icache"},  {62'd0, icache},  model[3]);
    chk({tag, "_dcache"},  {62'd0, dcache},  model[4]);
    chk({tag, "_cce"},     {63'd0, cce},     model[5]);
  endtask

  // Yumi policy: 0 = take immediately, 1 = random delay, 2 = hold off.
  int    mode = 0;
  logic  first = 1'b1;
  resp_t held;

  always @(negedge clk) begin
    if (bus.resp_v_o) begin
      if (first) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          held = exp_q.pop_front();
          chk("resp_w",    {63'd0, bus.resp_w_o},   {63'd0, held.w});
          chk("resp_err",  {63'd0, bus.resp_err_o}, {63'd0, held.err});
          chk("resp_data", bus.resp_data_o,         held.data);
          chk_cfg("resp_cfg");
        end
        first = 1'b0;
      end else begin
        chk("hold_w",     {63'd0, bus.resp_w_o},    {63'd0, held.w});
        chk("hold_err",   {63'd0, bus.resp_err_o},  {63'd0, held.err});
        chk("hold_data",  bus.resp_data_o,          held.data);
        chk("hold_ready", {63'd0, bus.cmd_ready_o}, 64'd0);
      end
      case (mode)
        0:       bus.resp_yumi_i = 1'b1;
        1:       bus.resp_yumi_i = ($urandom_range(0, 2) == 0);
        default: bus.resp_yumi_i = 1'b0;
      endcase
      if (bus.resp_yumi_i) first = 1'b1;
    end else begin
      bus.resp_yumi_i = 1'b0;
      first = 1'b1;
    end
  end

  time acc_t;

  task automatic issue(input logic w, input logic [15:0] a, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_v_i    = 1'b1;
    bus.cmd_w_i    = w;
    bus.cmd_addr_i = a;
    bus.cmd_data_i = d;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready_o) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.cmd_v_i = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    exp_q.push_back(predict(w, a, d));
    #1 bus.cmd_v_i = 1'b0;
    @(negedge clk);
    chk("latency_resp_v", {63'd0, bus.resp_v_o}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.resp_v_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    time prev_t;
    logic [15:0] a;
    int r;

    reset = 1'b1;
    bus.cmd_v_i = 1'b0;
    bus.cmd_w_i = 1'b0;
    bus.cmd_addr_i = '0;
    bus.cmd_data_i = '0;
    bus.resp_yumi_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready",  {63'd0, bus.cmd_ready_o}, 64'd0);
    chk("rst_resp_v", {63'd0, bus.resp_v_o},    64'd0);
    chk("rst_resp_w", {63'd0, bus.resp_w_o},    64'd0);
    chk("rst_err",    {63'd0, bus.resp_err_o},  64'd0);
    chk("rst_data",   bus.resp_data_o,          64'd0);
    chk_cfg("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, bus.cmd_ready_o}, 64'd1);

    mode = 0;
    issue(1'b0, 16'h00, 64'd0);
    issue(1'b0, 16'h30, 64'd0);
    issue(1'b1, 16'h08, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("core_id_on_resp", {61'd0, core_id}, 64'd5);
    issue(1'b0, 16'h08, 64'd0);
    drain();

    // Hold response for several cycles while a second command waits.
    mode = 2;
    issue(1'b1, 16'h00, 64'd0);
    chk("freeze_first_resp", {63'd0, freeze}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      bus.cmd_v_i = 1'b1;
      bus.cmd_w_i = 1'b1;
      bus.cmd_addr_i = 16'h08;
      bus.cmd_data_i = 64'd3;
      @(negedge clk);
      chk("held_ready",   {63'd0, bus.cmd_ready_o}, 64'd0);
      chk("held_resp_v",  {63'd0, bus.resp_v_o},    64'd1);
      chk("held_core_id", {61'd0, core_id},         model[1]);
    end
    bus.cmd_v_i = 1'b0;
    mode = 0;
    drain();

    issue(1'b1, 16'h30, 64'd7);
    issue(1'b0, 16'h30, 64'd0);
    issue(1'b0, 16'h38, 64'd0);
    issue(1'b0, 16'h0C, 64'd0);
    issue(1'b1, 16'h1008, 64'd6);
    drain();

    // Back-to-back with immediate yumi: one acceptance every two cycles.
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 16'h18, 64'(i));
      if (i > 0) chk("b2b_spacing", 64'(acc_t - prev_t), 64'd20);
      prev_t = acc_t;
    end
    drain();
    chk("icache_after_b2b", {62'd0, icache}, 64'd1);

    mode = 1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 16'(r * 8);
      else if (r == 7) a = 16'($urandom_range(0, 16'hFFFF));
      else if (r == 8) a = 16'($urandom_range(0, 6) * 8) | 16'h0100;
      else             a = 16'($urandom_range(0, 6) * 8 + $urandom_range(1, 7));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    drain();

    // Reset while a write response is pending; a write presented during reset is dropped.
    mode = 2;
    issue(1'b1, 16'h28, 64'd1);
    chk("cce_set", {63'd0, cce}, 64'd1);
    reset = 1'b1;
    bus.cmd_v_i = 1'b1;
    bus.cmd_w_i = 1'b1;
    bus.cmd_addr_i = 16'h08;
    bus.cmd_data_i = 64'd7;
    @(negedge clk);
    model_reset();
    exp_q.delete();
    chk("midrst_resp_v",  {63'd0, bus.resp_v_o},    64'd0);
    chk("midrst_ready",   {63'd0, bus.cmd_ready_o}, 64'd0);
    chk("midrst_err",     {63'd0, bus.resp_err_o},  64'd0);
    chk("midrst_data",    bus.resp_data_o,          64'd0);
    chk_cfg("midrst");
    bus.cmd_v_i = 1'b0;
    reset = 1'b0;
    mode = 0;
    @(negedge clk);
    chk("after_rst_ready",   {63'd0, bus.cmd_ready_o}, 64'd1);
    chk("after_rst_core_id", {61'd0, core_id},         64'd0);
    issue(1'b0, 16'h28, 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
